// File: rtl/aes_pkg.sv
// Shared AES constants: byte width, forward/inverse S-box tables and the
// SubBytes engine FSM state type.
package aes_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/aes_sbox.sv
// Single combinational S-box lane; the inverse table is only built when
// INV_EN is set.
module aes_sbox
   import aes_pkg::*;
#(
   parameter bit INV_EN = 1'b1
) (
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              inv,
   output logic [BYTE_W-1:0] byte_out
);

   if (INV_EN) begin : g_inv
      always_comb byte_out = inv ? INV_SBOX[byte_in] : SBOX[byte_in];
   end else begin : g_fwd
      logic unused_inv;
      assign unused_inv = inv;
      always_comb byte_out = SBOX[byte_in];
   end

endmodule

// File: rtl/sub_bytes_seq.sv
// Multi-cycle AES SubBytes engine: accepts a state, substitutes LANES bytes
// per cycle in place, then presents the result over a valid/ready handshake.
module sub_bytes_seq
   import aes_pkg::*;
#(
   parameter int unsigned STATE_WIDTH = 128,
   parameter int unsigned LANES       = 4,
   parameter bit          INV_EN      = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [STATE_WIDTH-1:0] in_data,
   input  logic                   in_inv,
   input  logic                   in_vld,
   output logic                   in_rdy,
   output logic [STATE_WIDTH-1:0] out_data,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic                   busy
);

   localparam int unsigned NBYTES = STATE_WIDTH / BYTE_W;
   localparam int unsigned NCHUNK = (LANES == 0) ? 1 : NBYTES / LANES;
   localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int unsigned LANE_W = LANES * BYTE_W;

   if ((STATE_WIDTH % BYTE_W) != 0 || LANES == 0 ||
       ((LANES == 0) ? 1 : (NBYTES % LANES)) != 0) begin : g_bad_param
      $error("sub_bytes_seq: STATE_WIDTH must be a multiple of 8 and LANES a nonzero divisor of the byte count");
   end

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [STATE_WIDTH-1:0] data_q;
   logic                   mode_q;
   logic                   rdy_en_q;
   logic                   accept;
   logic                   last;
   logic [31:0]            base;
   logic [LANE_W-1:0]      lane_in;
   logic [LANE_W-1:0]      lane_out;

   // Lane mux: the current chunk is read and written through the same slice
   assign base    = 32'(cnt_q) * LANE_W;
   assign lane_in = data_q[base +: LANE_W];

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      aes_sbox #(.INV_EN(INV_EN)) u_sbox (
         .byte_in  (lane_in[j*BYTE_W +: BYTE_W]),
         .inv      (mode_q),
         .byte_out (lane_out[j*BYTE_W +: BYTE_W])
      );
   end

   // Next-state and handshake decode
   always_comb begin
      state_d = state_q;
      in_rdy  = 1'b0;
      last    = (cnt_q == CNT_W'(NCHUNK - 1));
      case (state_q)
         IDLE: begin
            in_rdy = rdy_en_q;
            if (in_vld && rdy_en_q) state_d = SUB;
         end
         SUB: begin
            if (last) state_d = DONE;
         end
         DONE: begin
            in_rdy = out_rdy;
            if (out_rdy) state_d = in_vld ? SUB : IDLE;
         end
         default: state_d = IDLE;
      endcase
      accept = in_vld & in_rdy;
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         data_q   <= '0;
         mode_q   <= 1'b0;
         rdy_en_q <= 1'b0;
         out_vld  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         rdy_en_q <= 1'b1;
         out_vld  <= (state_d == DONE);
         busy     <= (state_d != IDLE);
         if (accept) begin
            data_q <= in_data;
            mode_q <= in_inv;
            cnt_q  <= '0;
         end else if (state_q == SUB) begin
            data_q[base +: LANE_W] <= lane_out;
            if (!last) cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign out_data = data_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Scoreboard bench for sub_bytes_seq: three instances (LANES 4, 1, 16) checked
// against an S-box model derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_seq;

   localparam int NI = 3;

   typedef struct {
      int           inst;
      logic [127:0] data;
      int           acc;
   } item_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] in_data  [NI];
   logic         in_inv   [NI];
   logic         in_vld   [NI];
   logic         in_rdy   [NI];
   logic [127:0] out_data [NI];
   logic         out_vld  [NI];
   logic         out_rdy  [NI];
   logic         busy     [NI];

   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   int    rdy_mode = 0;
   bit    seen [NI];
   item_t sb_q [$];
   logic [7:0] fwd_t [256];
   logic [7:0] inv_t [256];

   for (genvar k = 0; k < NI; k++) begin : g_dut
      localparam int unsigned L = (k == 0) ? 4 : (k == 1) ? 1 : 16;
      sub_bytes_seq #(.STATE_WIDTH(128), .LANES(L), .INV_EN(1'b1)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_data  (in_data[k]),
         .in_inv   (in_inv[k]),
         .in_vld   (in_vld[k]),
         .in_rdy   (in_rdy[k]),
         .out_data (out_data[k]),
         .out_vld  (out_vld[k]),
         .out_rdy  (out_rdy[k]),
         .busy     (busy[k])
      );
   end

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int nchunk(int k);
      return (k == 0) ? 4 : (k == 1) ? 16 : 1;
   endfunction

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic       hi;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = a << 1;
         if (hi) a = a ^ 8'h1b;
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(logic [7:0] x, int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   task automatic build_model();
      logic [7:0] b, s;
      for (int i = 0; i < 256; i++) begin
         b = 8'h00;
         for (int j = 1; j < 256; j++)
            if (gmul(8'(i), 8'(j)) == 8'h01) b = 8'(j);
         s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
         fwd_t[i] = s;
         inv_t[s] = 8'(i);
      end
   endtask

   function automatic logic [127:0] ref_sub(logic [127:0] d, logic inv);
      logic [127:0] r;
      for (int i = 0; i < 16; i++)
         r[8*i +: 8] = inv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
      return r;
   endfunction

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h expected %h", name, act, exp);
      end
   endtask

   // Drive one state into instance k; called at a falling edge, returns at one
   task automatic send(int k, logic [127:0] d, logic inv, logic [127:0] exp, output int acc);
      bit ok = 1'b0;
      item_t it;
      acc = -1;
      in_data[k] = d;
      in_inv[k]  = inv;
      in_vld[k]  = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
         #1;
         if (in_rdy[k]) begin
            @(posedge clk);
            ok = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      @(negedge clk);
      in_vld[k] = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout inst %0d actual no_accept expected accept", k);
      end else begin
         acc     = cyc;
         it.inst = k;
         it.data = exp;
         it.acc  = cyc;
         sb_q.push_back(it);
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 1000 && sb_q.size() != 0; t++) @(negedge clk);
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual %0d pending expected 0", sb_q.size());
         sb_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   // Downstream ready generator: 0 = always ready, 1 = random, 2 = stalled
   initial begin
      for (int k = 0; k < NI; k++) out_rdy[k] = 1'b1;
      forever begin
         @(negedge clk);
         for (int k = 0; k < NI; k++)
            out_rdy[k] = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom % 2) : 1'b0;
      end
   end

   // Monitor: latency on the rising out_vld, data on each completed handshake
   initial begin
      for (int k = 0; k < NI; k++) seen[k] = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            for (int k = 0; k < NI; k++) begin
               if (out_vld[k] && !seen[k]) begin
                  seen[k] = 1'b1;
                  if (sb_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_vld inst %0d actual %h expected none", k, out_data[k]);
                  end else begin
                     check("latency", 128'(cyc - sb_q[0].acc), 128'(nchunk(k)));
                  end
               end
               if (out_vld[k] && out_rdy[k] && sb_q.size() != 0) begin
                  check("inst", 128'(k), 128'(sb_q[0].inst));
                  check("out_data", out_data[k], sb_q[0].data);
                  void'(sb_q.pop_front());
                  seen[k] = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] d, e;
      logic         inv;
      int           acc, prev;
      bit           got;

      for (int k = 0; k < NI; k++) begin
         in_data[k] = '0;
         in_inv[k]  = 1'b0;
         in_vld[k]  = 1'b0;
      end
      rst_n = 1'b0;
      build_model();
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_vld", 128'(out_vld[0]), 128'(0));
      check("rst_busy", 128'(busy[0]), 128'(0));
      check("rst_in_rdy", 128'(in_rdy[0]), 128'(0));
      check("rst_out_data", out_data[0], 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rdy_before_edge", 128'(in_rdy[0]), 128'(0));
      @(negedge clk);
      #1;
      check("rdy_after_edge", 128'(in_rdy[0]), 128'(1));
      @(negedge clk);

      // Directed vectors on the LANES=4 instance
      send(0, 128'h0, 1'b0, {16{8'h63}}, acc);
      send(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230, acc);
      send(0, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808, acc);
      drain();

      // Backpressure: result held stable for 10 stalled cycles
      rdy_mode = 2;
      @(negedge clk);
      d = {$urandom, $urandom, $urandom, $urandom};
      e = ref_sub(d, 1'b0);
      send(0, d, 1'b0, e, acc);
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         #2;
         got = out_vld[0];
      end
      check("bp_vld_rise", 128'(got), 128'(1));
      repeat (10) begin
         check("bp_out_vld", 128'(out_vld[0]), 128'(1));
         check("bp_out_data", out_data[0], e);
         check("bp_in_rdy", 128'(in_rdy[0]), 128'(0));
         check("bp_busy", 128'(busy[0]), 128'(1));
         @(negedge clk);
         #2;
      end
      rdy_mode = 0;
      drain();

      // Back-to-back stream: one accept every NCHUNK+1 cycles
      prev = -1;
      for (int i = 0; i < 5; i++) begin
         d   = {$urandom, $urandom, $urandom, $urandom};
         inv = 1'($urandom % 2);
         send(0, d, inv, ref_sub(d, inv), acc);
         if (prev >= 0) check("b2b_spacing", 128'(acc - prev), 128'(5));
         prev = acc;
      end
      drain();

      // Random traffic with random backpressure
      rdy_mode = 1;
      for (int i = 0; i < 20; i++) begin
         d   = {$urandom, $urandom, $urandom, $urandom};
         inv = 1'($urandom % 2);
         send(0, d, inv, ref_sub(d, inv), acc);
         repeat ($urandom % 3) @(negedge clk);
      end
      drain();
      rdy_mode = 0;
      @(negedge clk);

      // Reset in the middle of SUB at cnt = 2
      d = {$urandom, $urandom, $urandom, $urandom};
      send(0, d, 1'b0, ref_sub(d, 1'b0), acc);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_vld", 128'(out_vld[0]), 128'(0));
      check("midrst_busy", 128'(busy[0]), 128'(0));
      sb_q.delete();
      for (int k = 0; k < NI; k++) seen[k] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230, acc);
      drain();

      // LANES=1 and LANES=16 instances
      for (int k = 1; k < NI; k++) begin
         send(k, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230, acc);
         send(k, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808, acc);
         for (int i = 0; i < 4; i++) begin
            d   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom % 2);
            send(k, d, inv, ref_sub(d, inv), acc);
         end
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
